// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences pipeline load/store requests onto a single-ported,
// word-organised data-memory bus with a req/ack handshake. Misaligned half/word
// accesses are split into two aligned word transactions; store byte masks and
// lane-shifted write data are built here, and load data is merged and extended.
//
// Ports
//   clk_in, rst_n_in         : clock, asynchronous active-low reset
//   req_valid_in/req_ready_o : pipeline request handshake (ready only in IDLE)
//   req_we_in, req_addr_in, req_size_in, req_unsigned_in, req_wdata_in : request
//   rsp_valid_o, rsp_rdata_o, rsp_err_o : one-cycle completion with load data / timeout error
//   dm_req_o/dm_ack_in       : memory bus handshake
//   dm_addr_o, dm_we_o, dm_wmask_o, dm_wdata_o, dm_rdata_in : memory bus payload
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        req_valid_in,
    output logic        req_ready_o,
    input  logic        req_we_in,
    input  logic [31:0] req_addr_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_unsigned_in,
    input  logic [31:0] req_wdata_in,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        dm_req_o,
    input  logic        dm_ack_in,
    output logic [31:0] dm_addr_o,
    output logic        dm_we_o,
    output logic [3:0]  dm_wmask_o,
    output logic [31:0] dm_wdata_o,
    input  logic [31:0] dm_rdata_in
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         size_q, size_d;
    logic               we_q, we_d;
    logic               uns_q, uns_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_lo_q, rdata_lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_ready_q, req_ready_d;
    logic               dm_req_q, dm_req_d;
    logic [31:0]        dm_addr_q, dm_addr_d;
    logic               dm_we_q, dm_we_d;
    logic [3:0]         dm_wmask_q, dm_wmask_d;
    logic [31:0]        dm_wdata_q, dm_wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;

    logic [1:0]         sel_off_c;
    logic [1:0]         sel_size_c;
    logic [31:0]        sel_wdata_c;
    logic [7:0]         base_mask_c;
    logic [63:0]        lane_data_c;
    logic [7:0]         lane_mask_c;
    logic               misaligned_c;
    logic [63:0]        load_buf_c;
    logic [31:0]        load_word_c;
    logic [31:0]        load_ext_c;
    logic               timeout_hit_c;
    logic               done_ok_c;
    logic               done_err_c;

    // Store lane data/mask: live request fields in IDLE, captured fields afterwards
    always_comb begin
        if (state_q == ST_IDLE) begin
            sel_off_c   = req_addr_in[1:0];
            sel_size_c  = req_size_in;
            sel_wdata_c = req_wdata_in;
        end else begin
            sel_off_c   = off_q;
            sel_size_c  = size_q;
            sel_wdata_c = wdata_q;
        end
        case (sel_size_c)
            2'b00:   base_mask_c = 8'h01;
            2'b01:   base_mask_c = 8'h03;
            default: base_mask_c = 8'h0F;
        endcase
        lane_data_c = 64'(sel_wdata_c) << {sel_off_c, 3'b000};
        lane_mask_c = base_mask_c << sel_off_c;
    end

    // A second word is needed whenever the access crosses a word boundary
    assign misaligned_c = ((size_q == 2'b01) && (off_q == 2'd3)) ||
                          (size_q[1] && (off_q != 2'd0));

    // Load merge: the ack'd word is the low half for ACC0, the high half for ACC1
    always_comb begin
        if (state_q == ST_ACC1) begin
            load_buf_c = {dm_rdata_in, rdata_lo_q};
        end else begin
            load_buf_c = {32'h0000_0000, dm_rdata_in};
        end
        load_word_c = 32'(load_buf_c >> {off_q, 3'b000});
        case (size_q)
            2'b00:   load_ext_c = uns_q ? {24'h00_0000, load_word_c[7:0]}
                                        : {{24{load_word_c[7]}}, load_word_c[7:0]};
            2'b01:   load_ext_c = uns_q ? {16'h0000, load_word_c[15:0]}
                                        : {{16{load_word_c[15]}}, load_word_c[15:0]};
            default: load_ext_c = load_word_c;
        endcase
    end

    // Abort fires on the cycle whose missing ack would bring the count to TIMEOUT_CYCLES
    assign timeout_hit_c = (TIMEOUT_CYCLES != 0) &&
                           (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        size_d      = size_q;
        we_d        = we_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        rdata_lo_d  = rdata_lo_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        dm_req_d    = dm_req_q;
        dm_addr_d   = dm_addr_q;
        dm_we_d     = dm_we_q;
        dm_wmask_d  = dm_wmask_q;
        dm_wdata_d  = dm_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        done_ok_c   = 1'b0;
        done_err_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_in) begin
                    state_d     = ST_ACC0;
                    off_d       = req_addr_in[1:0];
                    size_d      = req_size_in;
                    we_d        = req_we_in;
                    uns_d       = req_unsigned_in;
                    wdata_d     = req_wdata_in;
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
                    dm_req_d    = 1'b1;
                    dm_addr_d   = {req_addr_in[31:2], 2'b00};
                    dm_we_d     = req_we_in;
                    dm_wmask_d  = req_we_in ? lane_mask_c[3:0] : 4'h0;
                    dm_wdata_d  = req_we_in ? lane_data_c[31:0] : 32'h0000_0000;
                end
            end
            ST_ACC0, ST_ACC1: begin
                if (dm_ack_in) begin
                    rdata_lo_d = dm_rdata_in;
                    if ((state_q == ST_ACC0) && misaligned_c) begin
                        state_d    = ST_ACC1;
                        cnt_d      = '0;
                        dm_addr_d  = dm_addr_q + 32'd4;
                        dm_wmask_d = we_q ? lane_mask_c[7:4] : 4'h0;
                        dm_wdata_d = we_q ? lane_data_c[63:32] : 32'h0000_0000;
                    end else begin
                        done_ok_c = 1'b1;
                    end
                end else if (timeout_hit_c) begin
                    done_err_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase

        // Common completion path for normal end and timeout abort
        if (done_ok_c || done_err_c) begin
            state_d     = ST_RESP;
            dm_req_d    = 1'b0;
            dm_we_d     = 1'b0;
            dm_wmask_d  = 4'h0;
            dm_wdata_d  = 32'h0000_0000;
            rsp_valid_d = 1'b1;
            rsp_err_d   = done_err_c;
            rsp_rdata_d = (done_ok_c && !we_q) ? load_ext_c : 32'h0000_0000;
        end
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= 32'h0000_0000;
            rdata_lo_q  <= 32'h0000_0000;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            dm_req_q    <= 1'b0;
            dm_addr_q   <= 32'h0000_0000;
            dm_we_q     <= 1'b0;
            dm_wmask_q  <= 4'h0;
            dm_wdata_q  <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            size_q      <= size_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            rdata_lo_q  <= rdata_lo_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            dm_req_q    <= dm_req_d;
            dm_addr_q   <= dm_addr_d;
            dm_we_q     <= dm_we_d;
            dm_wmask_q  <= dm_wmask_d;
            dm_wdata_q  <= dm_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign dm_req_o    = dm_req_q;
    assign dm_addr_o   = dm_addr_q;
    assign dm_we_o     = dm_we_q;
    assign dm_wmask_o  = dm_wmask_q;
    assign dm_wdata_o  = dm_wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases plus randomized
// loads/stores against a byte-addressed memory model with random wait states.
module tb_dmem_access_ctrl;

    localparam int unsigned TMO = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        req_valid_in;
    logic        req_ready_o;
    logic        req_we_in;
    logic [31:0] req_addr_in;
    logic [1:0]  req_size_in;
    logic        req_unsigned_in;
    logic [31:0] req_wdata_in;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        dm_req_o;
    logic        dm_ack_in;
    logic [31:0] dm_addr_o;
    logic        dm_we_o;
    logic [3:0]  dm_wmask_o;
    logic [31:0] dm_wdata_o;
    logic [31:0] dm_rdata_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [logic [29:0]];

    always #5 clk_in = ~clk_in;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .req_valid_in    (req_valid_in),
        .req_ready_o     (req_ready_o),
        .req_we_in       (req_we_in),
        .req_addr_in     (req_addr_in),
        .req_size_in     (req_size_in),
        .req_unsigned_in (req_unsigned_in),
        .req_wdata_in    (req_wdata_in),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_rdata_o     (rsp_rdata_o),
        .rsp_err_o       (rsp_err_o),
        .dm_req_o        (dm_req_o),
        .dm_ack_in       (dm_ack_in),
        .dm_addr_o       (dm_addr_o),
        .dm_we_o         (dm_we_o),
        .dm_wmask_o      (dm_wmask_o),
        .dm_wdata_o      (dm_wdata_o),
        .dm_rdata_in     (dm_rdata_in)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [29:0] wi);
        if (mem.exists(wi)) return mem[wi];
        return {wi[21:0], 10'h15a} ^ 32'h5a5a_c3c3;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] ba);
        logic [31:0] w;
        w = mem_rd(ba[31:2]);
        return 8'(w >> {ba[1:0], 3'b000});
    endfunction

    // One request end to end: drive it, act as the memory, check bus and response
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata, input int max_wait,
                             input bit no_ack, output logic [31:0] rdata_obs);
        int          n;
        int          off;
        int          nacc;
        int          waits [2];
        logic [31:0] waddr [2];
        logic [3:0]  exp_mask [2];
        logic [31:0] exp_wd [2];
        logic [31:0] exp_val;
        int          a;
        int          left;
        int          bus_cyc;
        int          exp_bus;
        int          kk;
        bit          done;
        logic [31:0] wv;

        n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        off  = int'(addr[1:0]);
        nacc = (off + n > 4) ? 2 : 1;
        waddr[0] = addr & 32'hFFFF_FFFC;
        waddr[1] = waddr[0] + 32'd4;

        exp_val = 32'h0;
        for (int i = 0; i < n; i++) exp_val |= 32'(mem_byte(addr + 32'(i))) << (8 * i);
        if (n < 4 && !uns && exp_val[8*n-1]) exp_val |= 32'hFFFF_FFFF << (8 * n);
        if (we || no_ack) exp_val = 32'h0;

        for (int ai = 0; ai < 2; ai++) begin
            exp_mask[ai] = 4'h0;
            exp_wd[ai]   = 32'h0;
            for (int j = 0; j < 4; j++) begin
                kk = 4 * ai + j - off;
                if (we && kk >= 0 && kk < n) exp_mask[ai][j] = 1'b1;
                if (kk >= 0 && kk < 4) exp_wd[ai][8*j +: 8] = wdata[8*kk +: 8];
            end
            waits[ai] = int'($urandom_range(max_wait, 0));
        end
        exp_bus = no_ack ? int'(TMO) : (nacc + waits[0] + ((nacc == 2) ? waits[1] : 0));

        @(negedge clk_in);
        chk("ready_idle", 32'(req_ready_o), 32'd1);
        req_valid_in    = 1'b1;
        req_we_in       = we;
        req_addr_in     = addr;
        req_size_in     = size;
        req_unsigned_in = uns;
        req_wdata_in    = wdata;
        @(negedge clk_in);
        req_valid_in    = 1'b0;
        req_we_in       = 1'($urandom);
        req_addr_in     = $urandom;
        req_size_in     = 2'($urandom);
        req_unsigned_in = 1'($urandom);
        req_wdata_in    = $urandom;

        a = 0; left = waits[0]; bus_cyc = 0; done = 0; rdata_obs = 32'h0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            dm_ack_in = 1'b0;
            if (rsp_valid_o) begin
                done = 1;
                chk("rsp_cycle", 32'(cyc), 32'(1 + bus_cyc));
                chk("bus_cycles", 32'(bus_cyc), 32'(exp_bus));
                chk("acc_count", 32'(a), no_ack ? 32'd0 : 32'(nacc));
                chk("rsp_err", 32'(rsp_err_o), 32'(no_ack));
                chk("rsp_rdata", rsp_rdata_o, exp_val);
                rdata_obs = rsp_rdata_o;
            end else if (dm_req_o) begin
                bus_cyc++;
                chk("acc_in_range", 32'(a < nacc), 32'd1);
                if (a < nacc) begin
                    chk("dm_addr", dm_addr_o, waddr[a]);
                    chk("dm_we", 32'(dm_we_o), 32'(we));
                    chk("dm_wmask", 32'(dm_wmask_o), 32'(exp_mask[a]));
                    if (we) chk("dm_wdata", dm_wdata_o, exp_wd[a]);
                    if (!no_ack && left == 0) begin
                        dm_ack_in   = 1'b1;
                        dm_rdata_in = mem_rd(waddr[a][31:2]);
                        if (we) begin
                            wv = mem_rd(waddr[a][31:2]);
                            for (int j = 0; j < 4; j++)
                                if (exp_mask[a][j]) wv[8*j +: 8] = exp_wd[a][8*j +: 8];
                            mem[waddr[a][31:2]] = wv;
                        end
                        a++;
                        if (a < 2) left = waits[a];
                    end else begin
                        left--;
                    end
                end
            end
            if (!done) @(negedge clk_in);
        end
        if (!done) chk("rsp_seen", 32'd0, 32'd1);
        dm_ack_in = 1'b0;
        @(negedge clk_in);
        chk("rsp_pulse", 32'(rsp_valid_o), 32'd0);
        chk("ready_after", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] ra;
        logic [1:0]  rs;

        rst_n_in        = 1'b1;
        req_valid_in    = 1'b0;
        req_we_in       = 1'b0;
        req_addr_in     = 32'h0;
        req_size_in     = 2'b00;
        req_unsigned_in = 1'b0;
        req_wdata_in    = 32'h0;
        dm_ack_in       = 1'b0;
        dm_rdata_in     = 32'h0;
        #1 rst_n_in = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_dm_req", 32'(dm_req_o), 32'd0);
        chk("rst_dm_we", 32'(dm_we_o), 32'd0);
        chk("rst_dm_wmask", 32'(dm_wmask_o), 32'd0);
        chk("rst_dm_addr", dm_addr_o, 32'd0);
        chk("rst_dm_wdata", dm_wdata_o, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;

        mem[30'h0000_0040] = 32'hDEAD_BEEF;
        mem[30'h0000_003F] = 32'h0000_0000;
        mem[30'h0000_0080] = 32'h8012_3456;
        mem[30'h3FFF_FFFF] = 32'hAB00_0000;
        mem[30'h0000_0000] = 32'h0000_00CD;

        do_access(1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, 0, 1'b0, r);
        chk("word_load_0x100", r, 32'hDEAD_BEEF);
        do_access(1'b0, 32'h0000_0203, 2'b00, 1'b0, 32'h0, 0, 1'b0, r);
        chk("byte_load_signed", r, 32'hFFFF_FF80);
        do_access(1'b0, 32'h0000_0203, 2'b00, 1'b1, 32'h0, 0, 1'b0, r);
        chk("byte_load_unsigned", r, 32'h0000_0080);
        do_access(1'b1, 32'h0000_00FE, 2'b10, 1'b0, 32'h1122_3344, 0, 1'b0, r);
        do_access(1'b0, 32'h0000_00FC, 2'b10, 1'b0, 32'h0, 0, 1'b0, r);
        chk("split_store_lo", r, 32'h3344_0000);
        do_access(1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, 0, 1'b0, r);
        chk("split_store_hi", r, 32'hDEAD_1122);
        do_access(1'b0, 32'hFFFF_FFFF, 2'b01, 1'b0, 32'h0, 0, 1'b0, r);
        chk("wrap_half_load", r, 32'hFFFF_CDAB);

        // Timeout, then stray acks in IDLE must be dropped
        do_access(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0, 0, 1'b1, r);
        for (int i = 0; i < 3; i++) begin
            dm_ack_in = 1'b1;
            @(negedge clk_in);
            chk("stray_ack_req", 32'(dm_req_o), 32'd0);
            chk("stray_ack_rsp", 32'(rsp_valid_o), 32'd0);
        end
        dm_ack_in = 1'b0;
        do_access(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0, 3, 1'b0, r);

        // Reset during ACC1 wait states
        @(negedge clk_in);
        req_valid_in = 1'b1; req_we_in = 1'b0; req_addr_in = 32'h0000_0041;
        req_size_in = 2'b10; req_unsigned_in = 1'b0;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        chk("rst_test_acc0", 32'(dm_req_o), 32'd1);
        dm_ack_in = 1'b1;
        dm_rdata_in = mem_rd(30'h0000_0010);
        @(negedge clk_in);
        dm_ack_in = 1'b0;
        chk("rst_test_acc1_req", 32'(dm_req_o), 32'd1);
        chk("rst_test_acc1_addr", dm_addr_o, 32'h0000_0044);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk("midrst_dm_req", 32'(dm_req_o), 32'd0);
        chk("midrst_ready", 32'(req_ready_o), 32'd1);
        chk("midrst_rsp", 32'(rsp_valid_o), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("postrst_rsp", 32'(rsp_valid_o), 32'd0);
            chk("postrst_dm_req", 32'(dm_req_o), 32'd0);
        end
        chk("postrst_ready", 32'(req_ready_o), 32'd1);

        // Randomized loads/stores around low memory and the address wrap
        for (int t = 0; t < 60; t++) begin
            ra = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(7, 0)))
                                             : 32'($urandom_range(63, 0));
            rs = 2'($urandom);
            do_access(1'($urandom), ra, rs, 1'($urandom), $urandom, 3, 1'b0, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

- Sequences load/store requests from the execute stage onto a single-ported, word-organised data-memory bus using a req/ack handshake.
- Splits misaligned halfword/word accesses into two aligned word transactions, builds store byte masks and shifted write data.
- Merges and extends load data: byte/half zero- or sign-extended per `req_unsigned_in`.
- Sits between the pipeline's load/store datapath and data memory; holds the pipeline off via `req_ready_o` while an access is in flight.

## Interface
- `TIMEOUT_CYCLES`, default 16: max cycles one bus access may wait for `dm_ack_in` before abort; 0 disables timeout.
- `clk_in` in 1: clock, all state on rising edge.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `req_valid_in` in 1: pipeline request valid.
- `req_ready_o` out 1: controller can accept (high only in IDLE).
- `req_we_in` in 1: 1 store, 0 load.
- `req_addr_in` in 32: byte address.
- `req_size_in` in 2: 00 byte, 01 half, 10/11 word.
- `req_unsigned_in` in 1: zero-extend load (else sign-extend).
- `req_wdata_in` in 32: store data, right-justified.
- `rsp_valid_o` out 1: one-cycle completion pulse (loads and stores).
- `rsp_rdata_o` out 32: extended load data; 0 for stores and errors.
- `rsp_err_o` out 1: access aborted by timeout; valid with `rsp_valid_o`.
- `dm_req_o` out 1: bus request.
- `dm_ack_in` in 1: bus acknowledge; `dm_rdata_in` valid in ack cycle.
- `dm_addr_o` out 32: word-aligned address, bits [1:0] = 0.
- `dm_we_o` out 1: write.
- `dm_wmask_o` out 4: byte-lane write enables (0 for reads).
- `dm_wdata_o` out 32: lane-aligned write data.
- `dm_rdata_in` in 32: read data.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: `req_ready_o`=1; on `req_valid_in` capture addr/size/we/unsigned/wdata, go ACC0.
- Offset `off` = addr[1:0]; misaligned = (half and off=3) or (word and off≠0); byte never misaligned.
- ACC0 address {addr[31:2],00}; ACC1 address = ACC0 address + 4, wrapping mod 2^32 (0xFFFFFFFC -> 0x00000000).
- Store: 64-bit data = wdata << 8·off; 8-bit mask = (byte 0x01, half 0x03, word 0x0F) << off; ACC0 uses low 32 bits / low nibble, ACC1 the high halves.
- Load: ACC0 rdata -> buffer[31:0], ACC1 rdata -> buffer[63:32]; result = (buffer >> 8·off) truncated to size, then extended.
- ACC0: `dm_req_o`=1 with stable addr/we/mask/wdata until `dm_ack_in`. On ack: to ACC1 if misaligned, else RESP.
- ACC1: same handshake, on ack -> RESP.
- RESP: `rsp_valid_o`=1 for exactly one cycle, then IDLE.
- Timeout (`TIMEOUT_CYCLES`>0): per-access counter cleared on entry to ACC0/ACC1, increments each cycle without ack; at count = `TIMEOUT_CYCLES`, abort -> RESP with `rsp_err_o`=1, `rsp_rdata_o`=0; ACC1 skipped. Ack in the abort cycle wins (normal completion).
- `dm_ack_in` ignored in IDLE and RESP (late acks dropped).

## Timing
- Reset (async, immediate): state IDLE, `req_ready_o`=1, `dm_req_o`=0, `dm_we_o`=0, `dm_wmask_o`=0, `dm_addr_o`=0, `dm_wdata_o`=0, `rsp_valid_o`=0, `rsp_err_o`=0, `rsp_rdata_o`=0, counter 0.
- Reset mid-access: `dm_req_o` drops asynchronously; no response emitted.
- All `dm_*` and `rsp_*` outputs registered / state-decoded; no combinational path from `dm_ack_in` to `dm_req_o`.
- Zero-wait memory (ack in first req cycle):
  - Aligned: accept edge cycle 0, `dm_req_o` cycle 1, `rsp_valid_o` cycle 2, `req_ready_o` cycle 3.
  - Split: two consecutive `dm_req_o` cycles (1, 2), `dm_req_o` stays high across the boundary with new addr; rsp cycle 3.
- Each wait cycle adds one cycle of latency.
- `rsp_rdata_o`/`rsp_err_o` valid only while `rsp_valid_o`=1; held thereafter until next response.

## Test plan
- Aligned word load, addr 0x100, rdata 0xDEADBEEF, ack same cycle -> one bus access at 0x100, `rsp_rdata_o`=0xDEADBEEF two cycles after accept.
- Byte load signed, addr 0x203, rdata 0x80xxxxxx -> `rsp_rdata_o`=0xFFFFFF80; unsigned -> 0x00000080.
- Misaligned word store, addr 0x0FE, wdata 0x11223344 -> access 0x0FC mask 1100 wdata 0x33440000, then 0x100 mask 0011 wdata 0x00001122.
- Misaligned half load at 0xFFFFFFFF, rdata 0xAB000000 then 0x000000CD, signed -> addrs 0xFFFFFFFC, 0x00000000; `rsp_rdata_o`=0xFFFFCDAB.
- `TIMEOUT_CYCLES`=4, ack never asserted -> `dm_req_o` high 4 cycles then low; `rsp_valid_o`=1, `rsp_err_o`=1, rdata 0; a later stray ack ignored; `rsp_err_o`=0 on next request.
- Assert `rst_n_in` low during ACC1 with 3 wait states -> `dm_req_o` low immediately, no `rsp_valid_o`, `req_ready_o`=1 after release.
